// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its surroundings:
// the receiver side (tick, frame status, data), the consumer read port and
// the control/status lines. "slave" is the controller's view; "master" is
// the view of whatever drives it (receiver + consumer).
interface uart_rx_ctrl_if #(
  parameter int unsigned width      = 8,
  parameter int unsigned div_width  = 16,
  parameter int unsigned fifo_depth = 4
);
  localparam int unsigned cnt_w = $clog2(fifo_depth) + 1;

  logic                 enable;
  logic [div_width-1:0] divisor;
  logic                 baud_en_rx;
  logic                 rx_active;
  logic [width-1:0]     rx_data;
  logic                 rx_data_ready;
  logic [width-1:0]     rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [cnt_w-1:0]     fifo_count;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 idle_timeout;

  modport master (
    output enable, divisor, rx_active, rx_data, rx_data_ready, rd_ready, clr_overrun,
    input  baud_en_rx, rd_data, rd_valid, fifo_count, overrun, idle_timeout
  );

  modport slave (
    input  enable, divisor, rx_active, rx_data, rx_data_ready, rd_ready, clr_overrun,
    output baud_en_rx, rd_data, rd_valid, fifo_count, overrun, idle_timeout
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: programmable oversampling tick generator,
// edge-detected character capture into a first-word-fall-through FIFO,
// sticky overrun flag and a one-shot character-idle timeout.
module uart_rx_ctrl #(
  parameter int unsigned width         = 8,
  parameter int unsigned no_of_sample  = 16,
  parameter int unsigned div_width     = 16,
  parameter int unsigned fifo_depth    = 4,
  parameter int unsigned timeout_ticks = 4 * 10 * no_of_sample
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam int unsigned ptr_w = $clog2(fifo_depth);
  localparam int unsigned cnt_w = ptr_w + 1;
  localparam int unsigned tmo_w = $clog2(timeout_ticks + 1);

  typedef enum logic {
    st_armed,
    st_fired
  } tmo_state_e;

  logic [div_width-1:0] tick_cnt;
  logic                 baud_q;

  logic                 rdy_q;
  logic                 capture;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;

  logic [width-1:0]     mem [fifo_depth];
  logic [ptr_w-1:0]     wr_ptr;
  logic [ptr_w-1:0]     rd_ptr;
  logic [cnt_w-1:0]     count;
  logic                 overrun_q;

  logic [tmo_w-1:0]     tmo_cnt;
  logic                 reach_c;
  tmo_state_e           state;
  tmo_state_e           state_next;
  logic                 fire_c;
  logic                 idle_q;

  // Tick generator; >= compare recovers when divisor drops below the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      baud_q   <= 1'b0;
    end else if (!bus.enable) begin
      tick_cnt <= '0;
      baud_q   <= 1'b0;
    end else if (tick_cnt >= bus.divisor) begin
      tick_cnt <= '0;
      baud_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + div_width'(1);
      baud_q   <= 1'b0;
    end
  end

  // Completion level is registered so that only its rising edge captures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= bus.rx_data_ready;
  end

  assign capture = bus.rx_data_ready & ~rdy_q;
  assign full    = (count == cnt_w'(fifo_depth));
  assign pop     = bus.rd_valid & bus.rd_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the write
  assign wr_en   = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Storage array, written at the tail on an accepted capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(fifo_depth); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)   rd_ptr <= rd_ptr + ptr_w'(1);
    end
  end

  // Occupancy: net change of the write and pop in this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overrun_q <= 1'b0;
    else if (drop)            overrun_q <= 1'b1;
    else if (bus.clr_overrun) overrun_q <= 1'b0;
  end

  // Idle tick counter, cleared by line activity or a capture, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (bus.rx_active || capture) begin
      tmo_cnt <= '0;
    end else if (baud_q && (tmo_cnt != tmo_w'(timeout_ticks))) begin
      tmo_cnt <= tmo_cnt + tmo_w'(1);
    end
  end

  // The counter reaches the limit on this edge
  assign reach_c = baud_q && !bus.rx_active && !capture &&
                   (tmo_cnt == tmo_w'(timeout_ticks - 1));

  // Timeout arm state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_armed;
    else     state <= state_next;
  end

  // Fire once per arming when the limit is reached with data pending
  always_comb begin
    state_next = state;
    fire_c     = 1'b0;
    case (state)
      st_armed: begin
        if (reach_c && (count != '0)) begin
          fire_c     = 1'b1;
          state_next = st_fired;
        end
      end
      st_fired: begin
        state_next = st_fired;
      end
    endcase
    if (capture) state_next = st_armed;
  end

  // Registered one-cycle timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= 1'b0;
    else     idle_q <= fire_c;
  end

  assign bus.baud_en_rx   = baud_q;
  assign bus.rd_valid     = (count != '0);
  assign bus.rd_data      = mem[rd_ptr];
  assign bus.fifo_count   = count;
  assign bus.overrun      = overrun_q;
  assign bus.idle_timeout = idle_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int unsigned W     = 8;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int          T     = 640;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_ctrl_if #(.width(W), .div_width(DIV_W), .fifo_depth(DEPTH)) bus ();

  uart_rx_ctrl #(
    .width(W), .no_of_sample(16), .div_width(DIV_W),
    .fifo_depth(DEPTH), .timeout_ticks(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, counters as plain integers
  logic [7:0] m_q[$];
  int  m_since, m_idle, prev_idle, old_size;
  bit  m_tick, m_prev_rdy, m_ovr, m_armed, m_pulse;
  bit  cap_m, pop_m, drop_m, old_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_since = 0; m_tick = 0; m_prev_rdy = 0; m_ovr = 0;
      m_idle = 0; m_armed = 1; m_pulse = 0;
    end else begin
      old_tick = m_tick;
      old_size = m_q.size();
      cap_m = bus.rx_data_ready && !m_prev_rdy;
      pop_m = (old_size != 0) && bus.rd_ready;

      prev_idle = m_idle;
      if (bus.rx_active || cap_m) m_idle = 0;
      else if (old_tick && m_idle < T) m_idle = m_idle + 1;
      m_pulse = m_armed && (old_size != 0) && (prev_idle != T) && (m_idle == T);
      if (cap_m) m_armed = 1;
      else if (m_pulse) m_armed = 0;

      if (pop_m) void'(m_q.pop_front());
      drop_m = 0;
      if (cap_m) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.rx_data);
        else drop_m = 1;
      end
      if (drop_m) m_ovr = 1;
      else if (bus.clr_overrun) m_ovr = 0;

      // a tick whenever more than divisor cycles have passed since the last
      if (!bus.enable) begin
        m_since = 0; m_tick = 0;
      end else begin
        m_since = m_since + 1;
        m_tick = (m_since > int'(bus.divisor));
        if (m_tick) m_since = 0;
      end
      m_prev_rdy = bus.rx_data_ready;
    end
  end

  // Every-cycle compare of all outputs against the model
  always @(posedge clk) begin
    cyc++;
    #1;
    check("baud_en_rx", 32'(bus.baud_en_rx), 32'(m_tick));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
    check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("idle_timeout", 32'(bus.idle_timeout), 32'(m_pulse));
    if (m_q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(m_q[0]));
    if (bus.idle_timeout) begin
      pulses++;
      pulse_cyc = cyc;
    end
  end

  task automatic deliver(input logic [7:0] b, input int hold);
    bus.rx_data = b;
    bus.rx_data_ready = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_data_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, 32'(bus.rd_data), 32'(exp));
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
  endtask

  int p0, cap_cyc;

  initial begin
    bus.enable = 0; bus.divisor = '0; bus.rx_active = 0; bus.rx_data = '0;
    bus.rx_data_ready = 0; bus.rd_ready = 0; bus.clr_overrun = 0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_fifo_count", 32'(bus.fifo_count), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_baud", 32'(bus.baud_en_rx), 0);
    check("rst_idle", 32'(bus.idle_timeout), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    rst = 0;

    // tick generator: period divisor+1, divisor drop, disable
    @(negedge clk);
    bus.divisor = 16'd3; bus.enable = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("tick_div3", 32'(bus.baud_en_rx), 32'(k % 4 == 0));
    end
    bus.divisor = 16'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("tick_div0", 32'(bus.baud_en_rx), 1);
    end
    bus.enable = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("tick_off", 32'(bus.baud_en_rx), 0);
    end

    // single write for a long ready level, one clk latency
    bus.rx_data = 8'hA5; bus.rx_data_ready = 1;
    @(negedge clk);
    check("cap_latency_valid", 32'(bus.rd_valid), 1);
    check("cap_count", 32'(bus.fifo_count), 1);
    check("cap_data", 32'(bus.rd_data), 32'h A5);
    repeat (19) @(negedge clk);
    bus.rx_data_ready = 0;
    @(negedge clk);
    check("cap_single_write", 32'(bus.fifo_count), 1);
    pop_expect("pop_a5", 8'hA5);
    check("empty_after_pop", 32'(bus.fifo_count), 0);

    // overrun: five chars into four slots
    for (int b = 1; b <= 5; b++) deliver(8'(b), 3);
    check("full_count", 32'(bus.fifo_count), 4);
    check("overrun_set", 32'(bus.overrun), 1);
    bus.clr_overrun = 1;
    @(negedge clk);
    bus.clr_overrun = 0;
    check("overrun_clr", 32'(bus.overrun), 0);

    // full with simultaneous pop: write accepted at the tail
    check("head_01", 32'(bus.rd_data), 32'h01);
    bus.rx_data = 8'h06; bus.rx_data_ready = 1; bus.rd_ready = 1;
    @(negedge clk);
    bus.rd_ready = 0;
    check("swap_count", 32'(bus.fifo_count), 4);
    check("swap_overrun", 32'(bus.overrun), 0);
    @(negedge clk);
    bus.rx_data_ready = 0;
    @(negedge clk);
    pop_expect("pop_02", 8'h02);
    pop_expect("pop_03", 8'h03);
    pop_expect("pop_04", 8'h04);
    pop_expect("pop_06", 8'h06);
    check("drained", 32'(bus.fifo_count), 0);

    // idle timeout: one pulse exactly T ticks after capture
    bus.enable = 1; bus.divisor = 16'd0; bus.rx_active = 0;
    repeat (2) @(negedge clk);
    p0 = pulses;
    cap_cyc = cyc + 1;
    deliver(8'h3C, 2);
    repeat (700) @(negedge clk);
    check("timeout_once", 32'(pulses - p0), 1);
    check("timeout_latency", 32'(pulse_cyc - cap_cyc), 32'(T));
    repeat (1000) @(negedge clk);
    check("timeout_no_repeat", 32'(pulses - p0), 1);
    pop_expect("pop_3c", 8'h3C);
    p0 = pulses;
    deliver(8'h5A, 2);
    pop_expect("pop_5a", 8'h5A);
    repeat (1000) @(negedge clk);
    check("timeout_empty", 32'(pulses - p0), 0);

    // reset mid-activity
    bus.divisor = 16'd5;
    for (int b = 0; b < 3; b++) deliver(8'(8'h70 + b), 2);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("mid_rst_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_count", 32'(bus.fifo_count), 0);
    check("mid_rst_overrun", 32'(bus.overrun), 0);
    check("mid_rst_baud", 32'(bus.baud_en_rx), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("tick_after_rst", 32'(bus.baud_en_rx), 32'(k == 6));
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 2000) rst = 1;
      if (i == 2002) rst = 0;
      bus.rd_ready    = ($urandom_range(0, 3) < ((i < 2000) ? 1 : 3));
      bus.clr_overrun = ($urandom_range(0, 19) == 0);
      bus.rx_active   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.rx_data_ready = ~bus.rx_data_ready;
        if (bus.rx_data_ready) bus.rx_data = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) bus.divisor = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller for the UART receive datapath. It generates the programmable oversampling tick (baud_en_rx) that paces the receiver and captures each completed character into a small first-word-fall-through FIFO. It also flags overruns and raises a character-idle timeout. It sits between the receiver and the consuming logic (host interface or protocol engine).

Parameters:
width, 8, character width; must match the receiver.
no_of_sample, 16, oversampling ticks per bit; used only to derive the timeout default.
div_width, 16, width of the divisor input.
fifo_depth, 4, FIFO entries; must be a power of two and at least 2.
timeout_ticks, 640, baud ticks of line idle with data pending before idle_timeout fires (4 chars × 10 bits × no_of_sample).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  tick generator enable
divisor  in  div_width  one baud_en_rx tick every divisor+1 clk cycles
baud_en_rx  out  1  one-cycle sample tick to the receiver
rx_active  in  1  receiver is mid-frame
rx_data  in  width  receiver data_out
rx_data_ready  in  1  receiver completion flag; level, high for about one tick period
rd_data  out  width  FIFO head
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts rd_data
fifo_count  out  $clog2(fifo_depth)+1  current occupancy
overrun  out  1  sticky; a character was dropped
clr_overrun  in  1  clears overrun
idle_timeout  out  1  one-cycle pulse

Behaviour:
- Reset (async, rst=1): all outputs 0; tick counter, FIFO pointers, occupancy, edge register and timeout counter all 0; timeout armed. Reset mid-frame or mid-read discards FIFO contents.
- Tick generator, registered:
  - enable=0: counter=0, baud_en_rx=0.
  - enable=1: if counter >= divisor, then baud_en_rx=1 for one cycle and counter=0; else counter+1 and baud_en_rx=0.
  - divisor=0 gives a tick every clk.
  - A divisor change takes effect on the next compare. The >= compare prevents a lockup when divisor is lowered below the current count.
  - First tick after enable rises arrives divisor+1 cycles later.
- Capture:
  - rx_data_ready is registered as rdy_q; capture occurs on rx_data_ready & ~rdy_q.
  - Exactly one write per completed character, regardless of how long the level stays high.
  - rx_data is sampled in that same cycle.
- Write rules:
  - Not full: write at wr_ptr; wr_ptr wraps modulo fifo_depth.
  - Full with no pop in the same cycle: character dropped, overrun<=1, FIFO unchanged.
  - Full with a pop in the same cycle: the write is accepted and the count stays at fifo_depth.
- Read rules:
  - rd_valid = (count != 0).
  - rd_data = mem[rd_ptr], combinational from the register array, zero latency.
  - Pop when rd_valid & rd_ready; rd_ptr wraps. rd_ready while empty is ignored.
- Occupancy:
  - count +1 on write only, -1 on pop only, unchanged on both or neither.
  - fifo_count = count; it never exceeds fifo_depth and never underflows.
- Overrun:
  - Set on a dropped character; cleared by clr_overrun.
  - If a set and a clear occur in the same cycle, set wins.
- Idle timeout, counting baud_en_rx ticks:
  - The counter is cleared when rx_active=1 or on a capture.
  - Otherwise it increments on each tick, saturating at timeout_ticks.
  - When it reaches timeout_ticks, is armed, and count != 0: idle_timeout=1 for one clk, then disarm.
  - Re-arm on the next capture.
  - An empty FIFO never produces a pulse. The counter holds while enable=0.
- Latency: a character appears on rd_valid one clk after the rising edge of rx_data_ready.

Test Plan:
1. enable=1, divisor=3 -> baud_en_rx pulses every 4 clks, first pulse 4 clks after enable. Change divisor to 0 mid-count -> tick on the next clk, then every clk. enable=0 -> no ticks.
2. Drive rx_data=0xA5 with rx_data_ready held high 20 clks, rd_ready=0 -> fifo_count=1, rd_data=0xA5, rd_valid=1, no second write.
3. Deliver 0x01..0x05 with rd_ready=0, fifo_depth=4 -> count=4, overrun=1. Pops yield 0x01..0x04; 0x05 is lost. Pulse clr_overrun -> overrun=0.
4. FIFO full; rising edge of rx_data_ready with rd_ready=1 in the same cycle -> count stays 4, new byte stored at the tail, overrun stays 0.
5. One byte pending, rx_active=0, divisor=0, timeout_ticks=640 -> idle_timeout pulses once, 640 ticks after capture. No further pulse until a new capture. With the FIFO empty -> no pulse.
6. Assert rst with 3 bytes queued, mid-tick-count -> immediately rd_valid=0, fifo_count=0, overrun=0, baud_en_rx=0. After release, the first tick arrives divisor+1 clks later.
